// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Brief    : Single-word request responder driving a 256Kx16 asynchronous SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sram_req,
    input  logic        sram_rd,
    input  logic [1:0]  sram_be,
    input  logic [17:0] sram_addr,
    input  logic [15:0] sram_wr_data,
    output logic        sram_ready,
    output logic [15:0] sram_rd_data,
    output logic        sram_rd_data_vld,
    output logic [17:0] pin_a,
    output logic [15:0] pin_dq_o,
    output logic        pin_dq_oe,
    input  logic [15:0] pin_dq_i,
    output logic        pin_ce_n,
    output logic        pin_oe_n,
    output logic        pin_we_n,
    output logic        pin_lb_n,
    output logic        pin_ub_n
);

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_IDLE      = 3'd1,
        S_WR_SETUP  = 3'd2,
        S_WR_PULSE  = 3'd3,
        S_WR_HOLD   = 3'd4,
        S_RD_STROBE = 3'd5
    } state_t;

    localparam logic [3:0] C_RD_LOAD = 4'(RD_CYCLES - 1);
    localparam logic [3:0] C_WR_LOAD = 4'(WR_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [1:0]  r_be;
    logic [17:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rd_data;
    logic        r_vld;
    logic        r_ce_n, r_oe_n, r_we_n, r_lb_n, r_ub_n, r_dq_oe;

    logic        w_accept;
    logic        w_rd_last;
    logic [1:0]  w_be_nxt;
    logic        w_wr_nxt;
    logic        w_rd_nxt;

    assign w_accept  = (r_state == S_IDLE) && sram_req;
    assign w_rd_last = (r_state == S_RD_STROBE) && (r_cnt == 4'd0);
    assign w_be_nxt  = w_accept ? sram_be : r_be;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
        case (r_state)
            S_INIT: begin
                if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (sram_req) begin
                    if (sram_rd) begin
                        w_state_nxt = S_RD_STROBE;
                        w_cnt_nxt   = C_RD_LOAD;
                    end else begin
                        w_state_nxt = S_WR_SETUP;
                    end
                end
            end
            S_WR_SETUP: begin
                w_state_nxt = S_WR_PULSE;
                w_cnt_nxt   = C_WR_LOAD;
            end
            S_WR_PULSE: begin
                if (r_cnt == 4'd0) w_state_nxt = S_WR_HOLD;
            end
            S_WR_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            S_RD_STROBE: begin
                if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // Strobes are registered from the next state so the pads see glitch-free levels
    assign w_wr_nxt = (w_state_nxt == S_WR_SETUP) || (w_state_nxt == S_WR_PULSE) ||
                      (w_state_nxt == S_WR_HOLD);
    assign w_rd_nxt = (w_state_nxt == S_RD_STROBE);

    // Counter resets to 1 so INIT spans a full cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_INIT;
            r_cnt     <= 4'd1;
            r_be      <= 2'b00;
            r_addr    <= 18'h0;
            r_wdata   <= 16'h0;
            r_rd_data <= 16'h0;
            r_vld     <= 1'b0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_lb_n    <= 1'b1;
            r_ub_n    <= 1'b1;
            r_dq_oe   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_be    <= sram_be;
                r_addr  <= sram_addr;
                r_wdata <= sram_wr_data;
            end
            r_vld <= w_rd_last;
            if (w_rd_last) begin
                r_rd_data <= {r_be[1] ? pin_dq_i[15:8] : 8'h00,
                              r_be[0] ? pin_dq_i[7:0]  : 8'h00};
            end
            r_ce_n  <= ~(w_wr_nxt | w_rd_nxt);
            r_oe_n  <= ~w_rd_nxt;
            r_we_n  <= ~(w_state_nxt == S_WR_PULSE);
            r_dq_oe <= w_wr_nxt;
            r_lb_n  <= ~((w_wr_nxt | w_rd_nxt) & w_be_nxt[0]);
            r_ub_n  <= ~((w_wr_nxt | w_rd_nxt) & w_be_nxt[1]);
        end
    end

    assign sram_ready       = (r_state == S_IDLE);
    assign sram_rd_data     = r_rd_data;
    assign sram_rd_data_vld = r_vld;
    assign pin_a            = r_addr;
    assign pin_dq_o         = r_wdata;
    assign pin_dq_oe        = r_dq_oe;
    assign pin_ce_n         = r_ce_n;
    assign pin_oe_n         = r_oe_n;
    assign pin_we_n         = r_we_n;
    assign pin_lb_n         = r_lb_n;
    assign pin_ub_n         = r_ub_n;

endmodule
`default_nettype wire
